// File: rtl/fmac_sign_exp_stage_if.sv
// Operand/result handshake bundle for the FMAC sign/exponent stage.
// The master side produces operand triples and consumes results; the slave side is the stage.
interface fmac_sign_exp_stage_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic                   in_valid;
    logic                   in_ready;
    logic [W-1:0]           a;
    logic [W-1:0]           b;
    logic [W-1:0]           c;
    logic                   out_valid;
    logic                   out_ready;
    logic                   prod_sign;
    logic                   eff_sub;
    logic signed [EXP_W+1:0] prod_exp;
    logic signed [EXP_W+1:0] exp_diff;
    logic                   c_larger;
    logic [MAN_W:0]         mant_a;
    logic [MAN_W:0]         mant_b;
    logic [MAN_W:0]         mant_c;
    logic [2:0]             special;

    modport master (
        output in_valid, a, b, c, out_ready,
        input  in_ready, out_valid, prod_sign, eff_sub, prod_exp, exp_diff,
               c_larger, mant_a, mant_b, mant_c, special
    );

    modport slave (
        input  in_valid, a, b, c, out_ready,
        output in_ready, out_valid, prod_sign, eff_sub, prod_exp, exp_diff,
               c_larger, mant_a, mant_b, mant_c, special
    );
endinterface

// File: rtl/fmac_sign_exp_stage.sv
// First FMAC stage: unpacks A/B/C, forms product sign, effective-subtract, product exponent and
// alignment difference, buffered in a 2-entry skid FIFO. Define FMAC_SPECIAL_EN to add NaN/Inf/zero flags.
module fmac_sign_exp_stage #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 127
) (
    input  logic                 clk,
    input  logic                 rst,
    fmac_sign_exp_stage_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int XW = EXP_W + 2;

    typedef struct packed {
        logic           prod_sign;
        logic           eff_sub;
        logic [XW-1:0]  prod_exp;
        logic [XW-1:0]  exp_diff;
        logic [MAN_W:0] mant_a;
        logic [MAN_W:0] mant_b;
        logic [MAN_W:0] mant_c;
`ifdef FMAC_SPECIAL_EN
        logic [2:0]     special;
`endif
    } entry_t;

    // Zero/denormal exponents behave as exponent 1 with the hidden bit cleared.
    function automatic logic [XW-1:0] eff_exp(input logic [EXP_W-1:0] f);
        return (f == '0) ? XW'(1) : {2'b00, f};
    endfunction

    logic             sign_a, sign_b, sign_c;
    logic [EXP_W-1:0] exp_a, exp_b, exp_c;
    logic [MAN_W-1:0] frac_a, frac_b, frac_c;
    entry_t           new_entry;

`ifdef FMAC_SPECIAL_EN
    logic nan_a, nan_b, nan_c, inf_a, inf_b, inf_c, zero_a, zero_b;
    logic nan_any, inf_any;
`endif

    always_comb begin
        sign_a = bus.a[W-1];
        sign_b = bus.b[W-1];
        sign_c = bus.c[W-1];
        exp_a  = bus.a[W-2 -: EXP_W];
        exp_b  = bus.b[W-2 -: EXP_W];
        exp_c  = bus.c[W-2 -: EXP_W];
        frac_a = bus.a[MAN_W-1:0];
        frac_b = bus.b[MAN_W-1:0];
        frac_c = bus.c[MAN_W-1:0];

        new_entry           = '0;
        new_entry.prod_sign = sign_a ^ sign_b;
        new_entry.eff_sub   = sign_a ^ sign_b ^ sign_c;
        new_entry.prod_exp  = eff_exp(exp_a) + eff_exp(exp_b) - XW'(BIAS);
        new_entry.exp_diff  = eff_exp(exp_a) + eff_exp(exp_b) - XW'(BIAS) - eff_exp(exp_c);
        new_entry.mant_a    = {exp_a != '0, frac_a};
        new_entry.mant_b    = {exp_b != '0, frac_b};
        new_entry.mant_c    = {exp_c != '0, frac_c};

`ifdef FMAC_SPECIAL_EN
        nan_a   = (exp_a == '1) && (frac_a != '0);
        nan_b   = (exp_b == '1) && (frac_b != '0);
        nan_c   = (exp_c == '1) && (frac_c != '0);
        inf_a   = (exp_a == '1) && (frac_a == '0);
        inf_b   = (exp_b == '1) && (frac_b == '0);
        inf_c   = (exp_c == '1) && (frac_c == '0);
        zero_a  = (exp_a == '0) && (frac_a == '0);
        zero_b  = (exp_b == '0) && (frac_b == '0);
        nan_any = nan_a | nan_b | nan_c | (inf_a & zero_b) | (zero_a & inf_b);
        inf_any = ~nan_any & (inf_a | inf_b | inf_c);
        new_entry.special = {nan_any, inf_any, zero_a | zero_b};
`endif
    end

    logic [1:0] count_q, count_d;
    entry_t     slot0_q, slot0_d;
    entry_t     slot1_q, slot1_d;
    logic       push, pop;

    assign bus.in_ready  = (count_q != 2'd2) & ~rst;
    assign bus.out_valid = (count_q != 2'd0);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    // slot0 is always the head; push+pop can only coincide at count 1, replacing the head in place.
    always_comb begin
        count_d = count_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        if (push && pop) begin
            slot0_d = new_entry;
        end else if (push) begin
            if (count_q == 2'd0) begin
                slot0_d = new_entry;
            end else begin
                slot1_d = new_entry;
            end
            count_d = count_q + 2'd1;
        end else if (pop) begin
            slot0_d = slot1_q;
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            count_q <= count_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

    assign bus.prod_sign = slot0_q.prod_sign;
    assign bus.eff_sub   = slot0_q.eff_sub;
    assign bus.prod_exp  = slot0_q.prod_exp;
    assign bus.exp_diff  = slot0_q.exp_diff;
    assign bus.c_larger  = slot0_q.exp_diff[XW-1];
    assign bus.mant_a    = slot0_q.mant_a;
    assign bus.mant_b    = slot0_q.mant_b;
    assign bus.mant_c    = slot0_q.mant_c;
`ifdef FMAC_SPECIAL_EN
    assign bus.special   = slot0_q.special;
`else
    assign bus.special   = 3'b000;
`endif

endmodule

// File: tb/tb_fmac_sign_exp_stage.sv
// Testbench for fmac_sign_exp_stage: directed cases plus randomized traffic against a
// queue-based reference model of the FIFO and the IEEE field arithmetic.
module tb_fmac_sign_exp_stage;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fmac_sign_exp_stage_if bus ();

    fmac_sign_exp_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit       prod_sign;
        bit       eff_sub;
        int       prod_exp;
        int       exp_diff;
        bit       c_larger;
        int       mant_a;
        int       mant_b;
        int       mant_c;
        bit [2:0] special;
    } result_t;

    result_t ref_q[$];
    int      vectors     = 0;
    int      miscompares = 0;
    bit      last_accept = 1'b1;

    function automatic int eff_exp(input logic [31:0] x);
        return (x[30:23] == 8'd0) ? 1 : int'(x[30:23]);
    endfunction

    function automatic int mant_of(input logic [31:0] x);
        return ((x[30:23] != 8'd0) ? 32'h0080_0000 : 0) + int'(x[22:0]);
    endfunction

    function automatic result_t predict(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        result_t r;
        bit nan_v, inf_v, a_inf, b_inf, c_inf, a_zero, b_zero;
        r.prod_sign = a[31] ^ b[31];
        r.eff_sub   = r.prod_sign ^ c[31];
        r.prod_exp  = eff_exp(a) + eff_exp(b) - 127;
        r.exp_diff  = r.prod_exp - eff_exp(c);
        r.c_larger  = (r.exp_diff < 0);
        r.mant_a    = mant_of(a);
        r.mant_b    = mant_of(b);
        r.mant_c    = mant_of(c);
        a_inf  = (a[30:0] == 31'h7F80_0000);
        b_inf  = (b[30:0] == 31'h7F80_0000);
        c_inf  = (c[30:0] == 31'h7F80_0000);
        a_zero = (a[30:0] == 31'd0);
        b_zero = (b[30:0] == 31'd0);
        nan_v  = (a[30:0] > 31'h7F80_0000) || (b[30:0] > 31'h7F80_0000) || (c[30:0] > 31'h7F80_0000)
                 || (a_inf && b_zero) || (a_zero && b_inf);
        inf_v  = !nan_v && (a_inf || b_inf || c_inf);
        r.special = 3'b000;
`ifdef FMAC_SPECIAL_EN
        r.special = {nan_v, inf_v, a_zero || b_zero};
`endif
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 7))
            0: x = {x[31], 31'd0};
            1: x = {x[31], 8'hFF, 23'd0};
            2: x = {x[31], 8'hFF, x[22:1], 1'b1};
            3: x = {x[31], 8'h00, x[22:0]};
            default: ;
        endcase
        return x;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input result_t r);
        check("prod_sign", 64'(bus.prod_sign), 64'(r.prod_sign));
        check("eff_sub",   64'(bus.eff_sub),   64'(r.eff_sub));
        check("prod_exp",  64'(bus.prod_exp),  64'(r.prod_exp));
        check("exp_diff",  64'(bus.exp_diff),  64'(r.exp_diff));
        check("c_larger",  64'(bus.c_larger),  64'(r.c_larger));
        check("mant_a",    64'(bus.mant_a),    64'(r.mant_a));
        check("mant_b",    64'(bus.mant_b),    64'(r.mant_b));
        check("mant_c",    64'(bus.mant_c),    64'(r.mant_c));
        check("special",   64'(bus.special),   64'(r.special));
    endtask

    task automatic check_output();
        check("in_ready",  64'(bus.in_ready),  64'(!rst && ref_q.size() < 2));
        check("out_valid", 64'(bus.out_valid), 64'(ref_q.size() != 0));
        if (ref_q.size() != 0) check_head(ref_q[0]);
    endtask

    task automatic apply_stimulus(input bit v, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.c        = c;
    endtask

    // One clock: check at the falling edge, then advance the model with the edge's transfers.
    task automatic cycle();
        bit push, pop;
        @(negedge clk);
        check_output();
        push = bus.in_valid && !rst && (ref_q.size() < 2);
        pop  = bus.out_ready && (ref_q.size() != 0);
        @(posedge clk);
        if (rst) begin
            ref_q.delete();
        end else begin
            if (pop) void'(ref_q.pop_front());
            if (push) ref_q.push_back(predict(bus.a, bus.b, bus.c));
        end
        last_accept = push;
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.out_ready = 1'b0;
        apply_stimulus(1'b0, 32'd0, 32'd0, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_in_ready",  64'(bus.in_ready),  64'(0));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));

        // Basic field extraction
        $display("[TB] basic fields");
        bus.out_ready = 1'b1;
        apply_stimulus(1'b1, 32'h3F80_0000, 32'hC000_0000, 32'h3F00_0000);
        cycle();
        bus.in_valid = 1'b0;
        check("t1_out_valid", 64'(bus.out_valid), 64'(1));
        check("t1_prod_sign", 64'(bus.prod_sign), 64'(1));
        check("t1_eff_sub",   64'(bus.eff_sub),   64'(1));
        check("t1_prod_exp",  64'(bus.prod_exp),  64'(128));
        check("t1_exp_diff",  64'(bus.exp_diff),  64'(2));
        check("t1_c_larger",  64'(bus.c_larger),  64'(0));
        check("t1_mant_a",    64'(bus.mant_a),    64'(24'h800000));
        check("t1_mant_b",    64'(bus.mant_b),    64'(24'h800000));
        check("t1_mant_c",    64'(bus.mant_c),    64'(24'h800000));
        cycle();

        // Backpressure: fill both slots, then drain in order
        $display("[TB] backpressure");
        bus.out_ready = 1'b0;
        apply_stimulus(1'b1, rand_op(), rand_op(), rand_op());
        cycle();
        apply_stimulus(1'b1, rand_op(), rand_op(), rand_op());
        cycle();
        check("t2_full_in_ready", 64'(bus.in_ready), 64'(0));
        apply_stimulus(1'b1, rand_op(), rand_op(), rand_op());
        cycle();
        cycle();
        bus.out_ready = 1'b1;
        cycle();
        cycle();
        bus.in_valid = 1'b0;
        cycle();
        cycle();
        check("t2_drained", 64'(bus.out_valid), 64'(0));

        // Denormal operand with a larger addend exponent
        $display("[TB] denormal and c_larger");
        apply_stimulus(1'b1, 32'h0000_0001, 32'h3F80_0000, 32'h7F00_0000);
        cycle();
        bus.in_valid = 1'b0;
        check("t3_mant_a",   64'(bus.mant_a),   64'(24'h000001));
        check("t3_prod_exp", 64'(bus.prod_exp), 64'(1));
        check("t3_exp_diff", 64'(bus.exp_diff), 64'(-253));
        check("t3_c_larger", 64'(bus.c_larger), 64'(1));
        cycle();

        // Streaming at count 1
        $display("[TB] streaming");
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, rand_op(), rand_op(), rand_op());
            cycle();
            check("t4_out_valid", 64'(bus.out_valid), 64'(1));
            check("t4_in_ready",  64'(bus.in_ready),  64'(1));
        end
        bus.in_valid = 1'b0;
        cycle();

        // Reset with two buffered entries
        $display("[TB] reset mid-stream");
        bus.out_ready = 1'b0;
        apply_stimulus(1'b1, rand_op(), rand_op(), rand_op());
        cycle();
        apply_stimulus(1'b1, 32'hBF80_0000, 32'h4040_0000, 32'h3F80_0000);
        cycle();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        check("t5_out_valid", 64'(bus.out_valid), 64'(0));
        check("t5_in_ready",  64'(bus.in_ready),  64'(1));
        check("t5_prod_sign", 64'(bus.prod_sign), 64'(0));
        check("t5_eff_sub",   64'(bus.eff_sub),   64'(0));
        check("t5_prod_exp",  64'(bus.prod_exp),  64'(0));
        check("t5_exp_diff",  64'(bus.exp_diff),  64'(0));
        check("t5_c_larger",  64'(bus.c_larger),  64'(0));
        check("t5_mant_a",    64'(bus.mant_a),    64'(0));
        check("t5_mant_b",    64'(bus.mant_b),    64'(0));
        check("t5_mant_c",    64'(bus.mant_c),    64'(0));
        check("t5_special",   64'(bus.special),   64'(0));

        // Special-value flags: inf * zero
        $display("[TB] special flags");
        bus.out_ready = 1'b1;
        apply_stimulus(1'b1, 32'h7F80_0000, 32'h0000_0000, 32'h0000_0000);
        cycle();
        bus.in_valid = 1'b0;
`ifdef FMAC_SPECIAL_EN
        check("t6_special", 64'(bus.special), 64'(3'b101));
`else
        check("t6_special", 64'(bus.special), 64'(3'b000));
`endif
        cycle();

        // Randomized traffic with occasional resets
        $display("[TB] random traffic");
        last_accept = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!(bus.in_valid && !last_accept)) begin
                apply_stimulus($urandom_range(0, 3) != 0, rand_op(), rand_op(), rand_op());
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 59) == 0);
            cycle();
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        cycle();
        cycle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
